// File: rtl/padlock_pkg.sv
// Shared types and constants for the padlock code-entry controller.
package padlock_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned FAIL_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        LOCKOUT
    } state_e;

    // Index of the highest set bit; callers only pass one-hot or zero vectors.
    function automatic logic [DIGIT_W-1:0] onehot_to_digit(input logic [15:0] v);
        logic [DIGIT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = DIGIT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/padlock_if.sv
// Keypad-side and actuator-side signals of the padlock, grouped for port connection.
interface padlock_if
    import padlock_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS = 10
) ();

    logic [NUM_BUTTONS-1:0] but;
    logic                   open;
    logic                   lock;
    logic                   locked_out;
    logic [FAIL_W-1:0]      fail_count;

    modport master (
        output but,
        output open,
        input  lock,
        input  locked_out,
        input  fail_count
    );

    modport slave (
        input  but,
        input  open,
        output lock,
        output locked_out,
        output fail_count
    );

endinterface

// File: rtl/padlock_input_sync.sv
// Two-flop synchronizer and rising-edge classifier for the raw keypad pins.
// Events are registered, so a raw edge appears on the outputs three clocks later.
module padlock_input_sync
    import padlock_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] but_i,
    input  logic                   open_i,
    output logic                   digit_valid_o,
    output logic [DIGIT_W-1:0]     digit_o,
    output logic                   invalid_o,
    output logic                   open_evt_o
);

    logic [NUM_BUTTONS-1:0] butMeta_q;
    logic [NUM_BUTTONS-1:0] butSync_q;
    logic [NUM_BUTTONS-1:0] butPrev_q;
    logic                   openMeta_q;
    logic                   openSync_q;
    logic                   openPrev_q;
    logic [NUM_BUTTONS-1:0] butRise;
    logic                   digitHit;
    logic                   badHit;
    logic [DIGIT_W-1:0]     digitIdx;

    // A digit counts only when it is the sole button down; any other rise is a bad press.
    always_comb begin
        butRise  = butSync_q & ~butPrev_q;
        digitHit = $onehot(butRise) && (butSync_q == butRise);
        badHit   = (butRise != '0) && !digitHit;
        digitIdx = onehot_to_digit(16'(butRise));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            butMeta_q     <= '0;
            butSync_q     <= '0;
            butPrev_q     <= '0;
            openMeta_q    <= 1'b0;
            openSync_q    <= 1'b0;
            openPrev_q    <= 1'b0;
            digit_valid_o <= 1'b0;
            digit_o       <= '0;
            invalid_o     <= 1'b0;
            open_evt_o    <= 1'b0;
        end else begin
            butMeta_q     <= but_i;
            butSync_q     <= butMeta_q;
            butPrev_q     <= butSync_q;
            openMeta_q    <= open_i;
            openSync_q    <= openMeta_q;
            openPrev_q    <= openSync_q;
            digit_valid_o <= digitHit;
            digit_o       <= digitIdx;
            invalid_o     <= badHit;
            open_evt_o    <= openSync_q & ~openPrev_q;
        end
    end

endmodule

// File: rtl/padlock_sequencer.sv
// Code-entry controller: collects digits, checks them against CODE on open, drives the lock,
// and handles relock timing, entry timeout, failed-attempt counting and lockout.
module padlock_sequencer
    import padlock_pkg::*;
#(
    parameter int unsigned                 NUM_BUTTONS    = 10,
    parameter int unsigned                 CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE           = 16'h2507,
    parameter int unsigned                 MAX_FAILS      = 3,
    parameter int unsigned                 OPEN_CYCLES    = 1000,
    parameter int unsigned                 LOCKOUT_CYCLES = 100000,
    parameter int unsigned                 TIMEOUT_CYCLES = 50000
) (
    input logic      clk,
    input logic      rst_n,
    padlock_if.slave bus
);

    localparam int unsigned BUF_W   = CODE_LEN * DIGIT_W;
    localparam int unsigned TMAX_A  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMAX    = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int unsigned TIMER_W = $clog2(TMAX + 1);

    localparam logic [TIMER_W-1:0] OPEN_LAST    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         CODE_LEN_C   = 4'(CODE_LEN);
    localparam logic [FAIL_W-1:0]  MAX_FAILS_C  = FAIL_W'(MAX_FAILS);

    logic               digitValid;
    logic [DIGIT_W-1:0] digitVal;
    logic               invalidEvt;
    logic               openEvt;

    state_e             state_q;
    logic [BUF_W-1:0]   buf_q;
    logic [3:0]         count_q;
    logic               err_q;
    logic               ovf_q;
    logic               pend_q;
    logic [TIMER_W-1:0] timer_q;
    logic [FAIL_W-1:0]  fail_q;
    logic               lock_q;
    logic               lockedOut_q;

    logic [BUF_W-1:0]   buf_d;
    logic [TIMER_W-1:0] timer_d;
    logic [FAIL_W-1:0]  fail_d;
    logic               pass;

    padlock_input_sync #(
        .NUM_BUTTONS (NUM_BUTTONS)
    ) u_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .but_i         (bus.but),
        .open_i        (bus.open),
        .digit_valid_o (digitValid),
        .digit_o       (digitVal),
        .invalid_o     (invalidEvt),
        .open_evt_o    (openEvt)
    );

    // Shifting in from the bottom leaves the first digit in the top nibble once the buffer is full.
    always_comb begin
        buf_d   = BUF_W'({buf_q, digitVal});
        timer_d = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
        fail_d  = (fail_q < MAX_FAILS_C) ? fail_q + FAIL_W'(1) : fail_q;
        pass    = (count_q == CODE_LEN_C) && !ovf_q && !err_q && (buf_q == CODE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            timer_q     <= '0;
            fail_q      <= '0;
            lock_q      <= 1'b1;
            lockedOut_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ENTRY: begin
                    // A digit arriving with open is stored first; pend_q defers the check a cycle.
                    if (digitValid || invalidEvt) begin
                        state_q <= ENTRY;
                        timer_q <= '0;
                        pend_q  <= pend_q | openEvt;
                        if (invalidEvt) begin
                            err_q <= 1'b1;
                        end else if (count_q == CODE_LEN_C) begin
                            ovf_q <= 1'b1;
                        end else begin
                            buf_q   <= buf_d;
                            count_q <= count_q + 4'd1;
                        end
                    end else if (openEvt || pend_q) begin
                        state_q <= CHECK;
                        pend_q  <= 1'b0;
                        timer_q <= '0;
                    end else if (state_q == ENTRY) begin
                        if (timer_q == TIMEOUT_LAST) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                            buf_q   <= '0;
                            count_q <= '0;
                            err_q   <= 1'b0;
                            ovf_q   <= 1'b0;
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                end
                CHECK: begin
                    buf_q   <= '0;
                    count_q <= '0;
                    err_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    pend_q  <= 1'b0;
                    timer_q <= '0;
                    if (pass) begin
                        state_q <= OPEN;
                        lock_q  <= 1'b0;
                        fail_q  <= '0;
                    end else begin
                        fail_q <= fail_d;
                        if (fail_d == MAX_FAILS_C) begin
                            state_q     <= LOCKOUT;
                            lockedOut_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                OPEN: begin
                    if (openEvt) begin
                        timer_q <= '0;
                    end else if (timer_q == OPEN_LAST) begin
                        state_q <= IDLE;
                        lock_q  <= 1'b1;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                LOCKOUT: begin
                    if (timer_q == LOCKOUT_LAST) begin
                        state_q     <= IDLE;
                        lockedOut_q <= 1'b0;
                        fail_q      <= '0;
                        timer_q     <= '0;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    lock_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.lock       = lock_q;
    assign bus.locked_out = lockedOut_q;
    assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_padlock_sequencer.sv
// Directed bench for padlock_sequencer; timing parameters are shortened so lockout fits a short run.
module tb_padlock_sequencer;
    import padlock_pkg::*;

    localparam int unsigned NB = 10;
    localparam int unsigned CL = 4;
    localparam int unsigned MF = 3;
    localparam int unsigned OC = 1000;
    localparam int unsigned LC = 2000;
    localparam int unsigned TC = 500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc     = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    padlock_if #(.NUM_BUTTONS(NB)) bus ();

    padlock_sequencer #(
        .NUM_BUTTONS    (NB),
        .CODE_LEN       (CL),
        .CODE           (16'h2507),
        .MAX_FAILS      (MF),
        .OPEN_CYCLES    (OC),
        .LOCKOUT_CYCLES (LC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic pressDigit(input int d);
        @(negedge clk);
        bus.but    = '0;
        bus.but[d] = 1'b1;
        repeat (3) @(negedge clk);
        bus.but = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pressOpen();
        @(negedge clk);
        bus.open = 1'b1;
        repeat (3) @(negedge clk);
        bus.open = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Raises open but returns before the check completes, so the caller can time the result.
    task automatic raiseOpen();
        @(negedge clk);
        bus.open = 1'b1;
        repeat (3) @(negedge clk);
        bus.open = 1'b0;
    endtask

    // Digits are packed one per nibble, first digit in the most significant of n nibbles.
    task automatic enterCode(input logic [31:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            pressDigit(int'(seq[(n-1-i)*4 +: 4]));
        end
    endtask

    // which: 0 = lock, 1 = locked_out
    task automatic waitOut(input int which, input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 ? bus.lock : bus.locked_out) === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        nChecks++;
        if (bus.lock !== 1'b1) begin nFails++; $display("[TB] FAIL reset_lock: got %b want 1", bus.lock); end
        nChecks++;
        if (bus.locked_out !== 1'b0) begin nFails++; $display("[TB] FAIL reset_locked_out: got %b want 0", bus.locked_out); end
        nChecks++;
        if (bus.fail_count !== 4'd0) begin nFails++; $display("[TB] FAIL reset_fail_count: got %0d want 0", bus.fail_count); end
        rst_n = 1'b1;
        enterCode(32'h25, 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        nChecks++;
        if (bus.lock !== 1'b1 || bus.fail_count !== 4'd0) begin
            nFails++; $display("[TB] FAIL midreset_outputs: got lock=%b fail=%0d want lock=1 fail=0", bus.lock, bus.fail_count);
        end
        rst_n = 1'b1;
        enterCode(32'h2507, 4);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_then_open: got lock=%b want 0", bus.lock); end
        waitOut(0, 1'b1, OC + 20, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL midreset_relock: got lock=%b want 1 within budget", bus.lock); end
    endtask

    task automatic test_open();
        bit ok;
        int t0, t1;
        enterCode(32'h2507, 4);
        raiseOpen();
        waitOut(0, 1'b0, 20, ok);
        t0 = cyc;
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL open_unlock: got lock=%b want 0", bus.lock); end
        nChecks++;
        if (bus.fail_count !== 4'd0) begin nFails++; $display("[TB] FAIL open_fail_count: got %0d want 0", bus.fail_count); end
        waitOut(0, 1'b1, OC + 20, ok);
        t1 = cyc;
        nChecks++;
        if (!ok || (t1 - t0) != int'(OC)) begin
            nFails++; $display("[TB] FAIL open_duration: got %0d cycles want %0d", t1 - t0, OC);
        end
    endtask

    task automatic test_wrong_codes();
        enterCode(32'h250, 3);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b1 || bus.fail_count !== 4'd1) begin
            nFails++; $display("[TB] FAIL short_code: got lock=%b fail=%0d want lock=1 fail=1", bus.lock, bus.fail_count);
        end
        enterCode(32'h25077, 5);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b1 || bus.fail_count !== 4'd2) begin
            nFails++; $display("[TB] FAIL overflow_code: got lock=%b fail=%0d want lock=1 fail=2", bus.lock, bus.fail_count);
        end
    endtask

    task automatic test_lockout();
        bit ok;
        int t0, t1;
        enterCode(32'h2507, 4);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b0 || bus.fail_count !== 4'd0) begin
            nFails++; $display("[TB] FAIL success_clears_fails: got lock=%b fail=%0d want lock=0 fail=0", bus.lock, bus.fail_count);
        end
        waitOut(0, 1'b1, OC + 20, ok);
        for (int k = 1; k <= 2; k++) begin
            enterCode(32'h1111, 4);
            pressOpen();
            nChecks++;
            if (bus.fail_count !== 4'(k) || bus.locked_out !== 1'b0) begin
                nFails++; $display("[TB] FAIL wrong_%0d: got fail=%0d lo=%b want fail=%0d lo=0", k, bus.fail_count, bus.locked_out, k);
            end
        end
        enterCode(32'h1111, 4);
        raiseOpen();
        waitOut(1, 1'b1, 20, ok);
        t0 = cyc;
        nChecks++;
        if (!ok || bus.fail_count !== 4'd3) begin
            nFails++; $display("[TB] FAIL lockout_enter: got lo=%b fail=%0d want lo=1 fail=3", bus.locked_out, bus.fail_count);
        end
        enterCode(32'h2507, 4);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b1 || bus.locked_out !== 1'b1) begin
            nFails++; $display("[TB] FAIL lockout_ignores_code: got lock=%b lo=%b want lock=1 lo=1", bus.lock, bus.locked_out);
        end
        waitOut(1, 1'b0, LC + 20, ok);
        t1 = cyc;
        nChecks++;
        if (!ok || (t1 - t0) != int'(LC)) begin
            nFails++; $display("[TB] FAIL lockout_duration: got %0d cycles want %0d", t1 - t0, LC);
        end
        nChecks++;
        if (bus.fail_count !== 4'd0) begin nFails++; $display("[TB] FAIL lockout_exit_fails: got %0d want 0", bus.fail_count); end
        enterCode(32'h2507, 4);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b0) begin nFails++; $display("[TB] FAIL after_lockout_open: got lock=%b want 0", bus.lock); end
        waitOut(0, 1'b1, OC + 20, ok);
    endtask

    task automatic test_multi_press();
        @(negedge clk);
        bus.but    = '0;
        bus.but[2] = 1'b1;
        bus.but[5] = 1'b1;
        repeat (3) @(negedge clk);
        bus.but = '0;
        repeat (3) @(negedge clk);
        enterCode(32'h507, 3);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b1 || bus.fail_count !== 4'd1) begin
            nFails++; $display("[TB] FAIL multi_press: got lock=%b fail=%0d want lock=1 fail=1", bus.lock, bus.fail_count);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        enterCode(32'h25, 2);
        repeat (TC + 50) @(negedge clk);
        nChecks++;
        if (bus.fail_count !== 4'd1 || bus.lock !== 1'b1) begin
            nFails++; $display("[TB] FAIL timeout_keeps_fails: got fail=%0d lock=%b want fail=1 lock=1", bus.fail_count, bus.lock);
        end
        enterCode(32'h2507, 4);
        pressOpen();
        nChecks++;
        if (bus.lock !== 1'b0 || bus.fail_count !== 4'd0) begin
            nFails++; $display("[TB] FAIL timeout_then_open: got lock=%b fail=%0d want lock=0 fail=0", bus.lock, bus.fail_count);
        end
        waitOut(0, 1'b1, OC + 20, ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        enterCode(32'h250, 3);
        @(negedge clk);
        bus.but    = '0;
        bus.but[7] = 1'b1;
        bus.open   = 1'b1;
        repeat (3) @(negedge clk);
        bus.but  = '0;
        bus.open = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++;
        if (bus.lock !== 1'b0) begin nFails++; $display("[TB] FAIL digit_with_open: got lock=%b want 0", bus.lock); end
        waitOut(0, 1'b1, OC + 20, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL back_to_back_relock: got lock=%b want 1", bus.lock); end
    endtask

    initial begin
        bus.but  = '0;
        bus.open = 1'b0;
        test_reset();
        test_open();
        test_wrong_codes();
        test_lockout();
        test_multi_press();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
